// File: rtl/alu_seq.sv
// alu_seq: registered ALU with single-cycle ops and a WIDTH-cycle shift-add multiply.
// Ports: clk, rst_n (async low); start/op/a/b request; y/carry/zero/ovf result; busy, done.
module alu_seq #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [2:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] y,
    output logic             carry,
    output logic             zero,
    output logic             ovf,
    output logic             busy,
    output logic             done
);

    localparam int SW = $clog2(WIDTH);
    localparam int CW = $clog2(WIDTH) + 1;

    localparam logic [2:0] OP_ADD = 3'b000;
    localparam logic [2:0] OP_SUB = 3'b001;
    localparam logic [2:0] OP_AND = 3'b010;
    localparam logic [2:0] OP_OR  = 3'b011;
    localparam logic [2:0] OP_XOR = 3'b100;
    localparam logic [2:0] OP_SHL = 3'b101;
    localparam logic [2:0] OP_MUL = 3'b110;
    localparam logic [2:0] OP_SLT = 3'b111;

    typedef enum logic {
        S_IDLE = 1'b0,
        S_MUL  = 1'b1
    } state_t;

    state_t               r_state;
    state_t               w_state_nxt;
    logic [CW-1:0]        r_cnt;
    logic [2*WIDTH-1:0]   r_acc;
    logic [2*WIDTH-1:0]   r_mcand;
    logic [WIDTH-1:0]     r_mplier;
    logic [WIDTH-1:0]     r_y;
    logic                 r_carry;
    logic                 r_zero;
    logic                 r_ovf;
    logic                 r_done;

    logic                 w_accept;
    logic                 w_last;
    logic [WIDTH:0]       w_sum;
    logic [WIDTH:0]       w_diff;
    logic [SW-1:0]        w_shamt;
    logic [2*WIDTH-1:0]   w_shl;
    logic [2*WIDTH-1:0]   w_acc_nxt;
    logic [WIDTH-1:0]     w_res;
    logic                 w_res_c;
    logic                 w_res_v;

    assign w_sum   = {1'b0, a} + {1'b0, b};
    assign w_diff  = {1'b0, a} - {1'b0, b};
    assign w_shamt = SW'(32'(b) % 32'(WIDTH));
    // Bit WIDTH of the widened shift is the last bit pushed out of a.
    assign w_shl   = {{WIDTH{1'b0}}, a} << w_shamt;

    assign w_acc_nxt = r_mplier[0] ? (r_acc + r_mcand) : r_acc;

    assign w_accept = start && (r_state == S_IDLE);
    assign w_last   = (r_state == S_MUL) && (r_cnt == CW'(WIDTH - 1));

    always_comb begin
        w_res   = '0;
        w_res_c = 1'b0;
        w_res_v = 1'b0;
        unique case (op)
            OP_ADD: begin
                w_res   = w_sum[WIDTH-1:0];
                w_res_c = w_sum[WIDTH];
                w_res_v = (a[WIDTH-1] == b[WIDTH-1]) &&
                          (w_sum[WIDTH-1] != a[WIDTH-1]);
            end
            OP_SUB: begin
                w_res   = w_diff[WIDTH-1:0];
                w_res_c = w_diff[WIDTH];
                w_res_v = (a[WIDTH-1] != b[WIDTH-1]) &&
                          (w_diff[WIDTH-1] != a[WIDTH-1]);
            end
            OP_AND: w_res = a & b;
            OP_OR:  w_res = a | b;
            OP_XOR: w_res = a ^ b;
            OP_SHL: begin
                w_res   = w_shl[WIDTH-1:0];
                w_res_c = (w_shamt != '0) && w_shl[WIDTH];
            end
            OP_SLT: begin
                w_res = {{(WIDTH-1){1'b0}},
                         ($signed(a) < $signed(b))};
            end
            OP_MUL: w_res = '0;
            default: w_res = '0;
        endcase
    end

    always_comb begin
        w_state_nxt = r_state;
        unique case (r_state)
            S_IDLE: if (w_accept && op == OP_MUL) w_state_nxt = S_MUL;
            S_MUL:  if (w_last) w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= S_IDLE;
        else        r_state <= w_state_nxt;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt    <= '0;
            r_acc    <= '0;
            r_mcand  <= '0;
            r_mplier <= '0;
            r_y      <= '0;
            r_carry  <= 1'b0;
            r_zero   <= 1'b0;
            r_ovf    <= 1'b0;
            r_done   <= 1'b0;
        end else begin
            r_done <= 1'b0;
            if (w_accept) begin
                if (op == OP_MUL) begin
                    r_acc    <= '0;
                    r_mcand  <= {{WIDTH{1'b0}}, a};
                    r_mplier <= b;
                    r_cnt    <= '0;
                end else begin
                    r_y     <= w_res;
                    r_carry <= w_res_c;
                    r_zero  <= (w_res == '0);
                    r_ovf   <= w_res_v;
                    r_done  <= 1'b1;
                end
            end else if (r_state == S_MUL) begin
                r_acc    <= w_acc_nxt;
                r_mcand  <= r_mcand << 1;
                r_mplier <= r_mplier >> 1;
                if (w_last) begin
                    r_cnt   <= '0;
                    r_y     <= w_acc_nxt[WIDTH-1:0];
                    r_carry <= |w_acc_nxt[2*WIDTH-1:WIDTH];
                    r_zero  <= (w_acc_nxt[WIDTH-1:0] == '0);
                    r_ovf   <= 1'b0;
                    r_done  <= 1'b1;
                end else begin
                    r_cnt <= r_cnt + CW'(1);
                end
            end
        end
    end

    assign y     = r_y;
    assign carry = r_carry;
    assign zero  = r_zero;
    assign ovf   = r_ovf;
    assign busy  = (r_state == S_MUL);
    assign done  = r_done;

endmodule

// File: tb/tb_alu_seq.sv
// tb_alu_seq: directed vectors for alu_seq (WIDTH=8).
// Drives ops on negedge, samples 1ns after posedge.
module tb_alu_seq;

    logic       clk;
    logic       rst_n;
    logic       start;
    logic [2:0] op;
    logic [7:0] a;
    logic [7:0] b;
    logic [7:0] y;
    logic       carry;
    logic       zero;
    logic       ovf;
    logic       busy;
    logic       done;

    int n_checks = 0;
    int n_errors = 0;
    int n_done;

    alu_seq #(.WIDTH(8)) u_dut (
        .clk   (clk),
        .rst_n (rst_n),
        .start (start),
        .op    (op),
        .a     (a),
        .b     (b),
        .y     (y),
        .carry (carry),
        .zero  (zero),
        .ovf   (ovf),
        .busy  (busy),
        .done  (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic issue(input logic [2:0] o, input logic [7:0] va,
                         input logic [7:0] vb);
        @(negedge clk);
        start = 1'b1;
        op    = o;
        a     = va;
        b     = vb;
        @(posedge clk);
        #1;
        start = 1'b0;
        a     = 8'h00;
        b     = 8'h00;
    endtask

    task automatic chk_res(input string tag, input logic [7:0] ey,
                           input logic ec, input logic ez, input logic ev);
        chk({tag, ".y"}, 32'(y), 32'(ey));
        chk({tag, ".carry"}, 32'(carry), 32'(ec));
        chk({tag, ".zero"}, 32'(zero), 32'(ez));
        chk({tag, ".ovf"}, 32'(ovf), 32'(ev));
        chk({tag, ".done"}, 32'(done), 32'd1);
        chk({tag, ".busy"}, 32'(busy), 32'd0);
    endtask

    task automatic idle_cycle();
        @(posedge clk);
        #1;
    endtask

    // Runs a mul from accept through completion, checking busy/done per cycle.
    task automatic run_mul(input string tag, input logic [7:0] va,
                           input logic [7:0] vb);
        issue(3'b110, va, vb);
        chk({tag, ".busy0"}, 32'(busy), 32'd1);
        chk({tag, ".done0"}, 32'(done), 32'd0);
        for (int i = 1; i <= 8; i++) begin
            @(posedge clk);
            #1;
            if (i < 8) begin
                chk($sformatf("%s.busy%0d", tag, i), 32'(busy), 32'd1);
                chk($sformatf("%s.done%0d", tag, i), 32'(done), 32'd0);
            end
        end
    endtask

    initial begin
        rst_n = 1'b0;
        start = 1'b0;
        op    = 3'b000;
        a     = 8'h00;
        b     = 8'h00;
        #12;
        rst_n = 1'b1;
        #1;
        chk("rst.y", 32'(y), 32'd0);
        chk("rst.carry", 32'(carry), 32'd0);
        chk("rst.zero", 32'(zero), 32'd0);
        chk("rst.ovf", 32'(ovf), 32'd0);
        chk("rst.busy", 32'(busy), 32'd0);
        chk("rst.done", 32'(done), 32'd0);

        issue(3'b000, 8'hFF, 8'h01);
        chk_res("add_ff_01", 8'h00, 1'b1, 1'b1, 1'b0);
        idle_cycle();
        chk("add.done_drop", 32'(done), 32'd0);
        chk("add.y_hold", 32'(y), 32'h00);

        issue(3'b001, 8'h80, 8'h01);
        chk_res("sub_80_01", 8'h7F, 1'b0, 1'b0, 1'b1);
        issue(3'b001, 8'h01, 8'h02);
        chk_res("sub_01_02", 8'hFF, 1'b1, 1'b0, 1'b0);

        issue(3'b010, 8'hF0, 8'h3C);
        chk_res("and", 8'h30, 1'b0, 1'b0, 1'b0);
        issue(3'b011, 8'hF0, 8'h3C);
        chk_res("or", 8'hFC, 1'b0, 1'b0, 1'b0);
        issue(3'b100, 8'hAA, 8'hAA);
        chk_res("xor", 8'h00, 1'b0, 1'b1, 1'b0);
        issue(3'b101, 8'h81, 8'h09);
        chk_res("shl_1", 8'h02, 1'b1, 1'b0, 1'b0);
        issue(3'b101, 8'h81, 8'h08);
        chk_res("shl_0", 8'h81, 1'b0, 1'b0, 1'b0);
        issue(3'b101, 8'h03, 8'h07);
        chk_res("shl_7", 8'h80, 1'b1, 1'b0, 1'b0);
        issue(3'b111, 8'hFE, 8'h01);
        chk_res("slt_neg", 8'h01, 1'b0, 1'b0, 1'b0);
        issue(3'b111, 8'h01, 8'hFE);
        chk_res("slt_pos", 8'h00, 1'b0, 1'b1, 1'b0);
        idle_cycle();

        run_mul("mul_0f_11", 8'h0F, 8'h11);
        chk_res("mul_0f_11", 8'hFF, 1'b0, 1'b0, 1'b0);
        idle_cycle();
        chk("mul.done_drop", 32'(done), 32'd0);
        chk("mul.y_hold", 32'(y), 32'hFF);

        run_mul("mul_10_10", 8'h10, 8'h10);
        chk_res("mul_10_10", 8'h00, 1'b1, 1'b1, 1'b0);

        // 0x0D * 0x0B = 0x8F; an and is offered 3 cycles in.
        issue(3'b110, 8'h0D, 8'h0B);
        n_done = 0;
        for (int i = 1; i <= 12; i++) begin
            if (i == 3) begin
                @(negedge clk);
                start = 1'b1;
                op    = 3'b010;
                a     = 8'hF0;
                b     = 8'h3C;
            end
            @(posedge clk);
            #1;
            if (i == 3) start = 1'b0;
            if (done) n_done++;
            if (i == 8) begin
                chk("mul_ign.y", 32'(y), 32'h8F);
                chk("mul_ign.carry", 32'(carry), 32'd0);
                chk("mul_ign.done", 32'(done), 32'd1);
            end
        end
        chk("mul_ign.n_done", 32'(n_done), 32'd1);
        chk("mul_ign.y_final", 32'(y), 32'h8F);

        issue(3'b011, 8'hF0, 8'h0C);
        chk_res("or_pre_rst", 8'hFC, 1'b0, 1'b0, 1'b0);
        issue(3'b110, 8'h0F, 8'h11);
        idle_cycle();
        idle_cycle();
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst.y", 32'(y), 32'd0);
        chk("arst.carry", 32'(carry), 32'd0);
        chk("arst.zero", 32'(zero), 32'd0);
        chk("arst.ovf", 32'(ovf), 32'd0);
        chk("arst.busy", 32'(busy), 32'd0);
        chk("arst.done", 32'(done), 32'd0);
        for (int i = 0; i < 10; i++) begin
            @(posedge clk);
            #1;
            chk($sformatf("arst.nodone%0d", i), 32'(done), 32'd0);
        end
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(posedge clk);
            #1;
            chk($sformatf("rel.nodone%0d", i), 32'(done), 32'd0);
        end
        issue(3'b000, 8'h03, 8'h04);
        chk_res("add_3_4", 8'h07, 1'b0, 1'b0, 1'b0);
        idle_cycle();
        chk("add_3_4.done_drop", 32'(done), 32'd0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
